// File: rtl/dlo_dr_decoder.sv
// Dual-rail precharged receiver: completion-checks spacer/codeword cycles and queues decoded words.
// Latency: word sampled at edge k (dt_q), pushed at edge k+1; Q/QV registered from a 2-entry FIFO.
// Backpressure: QV/QR handshake; a push into a full FIFO with no same-cycle pop drops the word and flags overflow.
module dlo_dr_decoder #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             CP,
  input  logic             CDN,
  input  logic [WIDTH-1:0] DT,
  input  logic [WIDTH-1:0] DF,
  output logic [WIDTH-1:0] Q,
  output logic             QV,
  input  logic             QR,
  output logic             ERR,
  output logic [1:0]       ERR_CODE,
  input  logic             CLR_ERR
);

  typedef enum logic {
    WAIT_SPACER = 1'b0,
    WAIT_DATA   = 1'b1
  } state_t;

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  logic [WIDTH-1:0] dt_q, dt_d, df_q, df_d;
  logic             in_vld_q, in_vld_d;
  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d, cnt_inc;
  logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]       fcnt_q, fcnt_d;
  logic             qv_q, qv_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;

  logic is_ill, is_sp, is_comp;
  logic push_req, err_ill, err_to;
  logic pop, full, push, ovf;
  logic [1:0] new_code;

  // Word class of the registered rails: any 11 pair is illegal, all-00 is a spacer,
  // every pair one-hot is a complete codeword, anything else is still evaluating.
  assign is_ill  = |(dt_q & df_q);
  assign is_sp   = ~|(dt_q | df_q);
  assign is_comp = &(dt_q ^ df_q);
  assign cnt_inc = cnt_q + 8'd1;

  // Input sampling; in_vld marks that dt_q/df_q hold a real sample rather than
  // reset zeros, so a reset value is never mistaken for an observed spacer.
  always_comb begin
    dt_d     = DT;
    df_d     = DF;
    in_vld_d = 1'b1;
  end

  // Completion FSM with the stalled-evaluation counter.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    push_req = 1'b0;
    err_ill  = 1'b0;
    err_to   = 1'b0;
    if (in_vld_q) begin
      if (is_ill) begin
        err_ill = 1'b1;
        state_d = WAIT_SPACER;
        cnt_d   = 8'd0;
      end else if (state_q == WAIT_SPACER) begin
        // A codeword still present here is the previous word repeating.
        cnt_d = 8'd0;
        if (is_sp) state_d = WAIT_DATA;
      end else begin
        if (is_sp) begin
          cnt_d = 8'd0;
        end else if (is_comp) begin
          push_req = 1'b1;
          cnt_d    = 8'd0;
          state_d  = WAIT_SPACER;
        end else if (cnt_inc == TO_LIM) begin
          err_to  = 1'b1;
          cnt_d   = 8'd0;
          state_d = WAIT_SPACER;
        end else begin
          cnt_d = cnt_inc;
        end
      end
    end
  end

  // Two-entry FIFO as head/tail registers so Q keeps its last value once drained.
  always_comb begin
    pop    = qv_q & QR;
    full   = (fcnt_q == 2'd2);
    push   = push_req & (~full | pop);
    ovf    = push_req & full & ~pop;
    head_d = head_q;
    tail_d = tail_q;
    fcnt_d = fcnt_q;
    case (fcnt_q)
      2'd0: begin
        if (push) begin
          head_d = dt_q;
          fcnt_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = dt_q;
        end else if (push) begin
          tail_d = dt_q;
          fcnt_d = 2'd2;
        end else if (pop) begin
          fcnt_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_d = tail_q;
          if (push) tail_d = dt_q;
          else      fcnt_d = 2'd1;
        end
      end
    endcase
    qv_d = (fcnt_d != 2'd0);
  end

  // Sticky error: first code wins; a new error beats a same-cycle clear.
  always_comb begin
    new_code = err_ill ? 2'b01 : (ovf ? 2'b11 : (err_to ? 2'b10 : 2'b00));
    err_d    = err_q;
    code_d   = code_q;
    if ((new_code != 2'b00) && (!err_q || CLR_ERR)) begin
      err_d  = 1'b1;
      code_d = new_code;
    end else if (CLR_ERR) begin
      err_d  = 1'b0;
      code_d = 2'b00;
    end
  end

  // State registers.
  always_ff @(posedge CP or negedge CDN) begin
    if (!CDN) begin
      dt_q     <= '0;
      df_q     <= '0;
      in_vld_q <= 1'b0;
      state_q  <= WAIT_SPACER;
      cnt_q    <= 8'd0;
      head_q   <= '0;
      tail_q   <= '0;
      fcnt_q   <= 2'd0;
      qv_q     <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= 2'b00;
    end else begin
      dt_q     <= dt_d;
      df_q     <= df_d;
      in_vld_q <= in_vld_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      fcnt_q   <= fcnt_d;
      qv_q     <= qv_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  assign Q        = head_q;
  assign QV       = qv_q;
  assign ERR      = err_q;
  assign ERR_CODE = code_q;

endmodule

// File: tb/tb_dlo_dr_decoder.sv
// Bench for dlo_dr_decoder: directed scenarios plus randomized traffic against a queue-based model.
module tb_dlo_dr_decoder;
  localparam int W  = 8;
  localparam int TO = 15;

  logic         CP = 1'b0;
  logic         CDN = 1'b0;
  logic [W-1:0] DT = '0;
  logic [W-1:0] DF = '0;
  logic [W-1:0] Q;
  logic         QV;
  logic         QR = 1'b0;
  logic         ERR;
  logic [1:0]   ERR_CODE;
  logic         CLR_ERR = 1'b0;

  int checks = 0;
  int errors = 0;

  dlo_dr_decoder #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .CP(CP), .CDN(CDN), .DT(DT), .DF(DF), .Q(Q), .QV(QV), .QR(QR),
    .ERR(ERR), .ERR_CODE(ERR_CODE), .CLR_ERR(CLR_ERR)
  );

  always #5 CP = ~CP;

  // Reference model: sampled rails, "spacer seen" flag, stall count, FIFO queue, error latch.
  logic [W-1:0] m_dt, m_df;
  bit           m_sampled;
  bit           m_armed;
  int           m_stall;
  logic [W-1:0] m_fifo[$];
  logic [W-1:0] m_q;
  logic         m_err;
  logic [1:0]   m_code;

  function automatic void model_reset();
    m_dt = '0; m_df = '0; m_sampled = 0; m_armed = 0; m_stall = 0;
    m_fifo.delete(); m_q = '0; m_err = 1'b0; m_code = 2'b00;
  endfunction

  function automatic void model_step();
    int n_ill = 0;
    int n_sp = 0;
    int n_val = 0;
    bit e_ill = 0;
    bit e_to = 0;
    bit e_ov = 0;
    bit push_req = 0;
    bit pop;
    logic [1:0] code;
    for (int i = 0; i < W; i++) begin
      if (m_dt[i] && m_df[i]) n_ill++;
      else if (!m_dt[i] && !m_df[i]) n_sp++;
      else n_val++;
    end
    if (m_sampled) begin
      if (n_ill > 0) begin
        e_ill = 1; m_armed = 0; m_stall = 0;
      end else if (!m_armed) begin
        m_stall = 0;
        if (n_sp == W) m_armed = 1;
      end else if (n_sp == W) begin
        m_stall = 0;
      end else if (n_val == W) begin
        push_req = 1; m_stall = 0; m_armed = 0;
      end else begin
        m_stall++;
        if (m_stall >= TO) begin
          e_to = 1; m_stall = 0; m_armed = 0;
        end
      end
    end
    pop = (m_fifo.size() > 0) && (QR === 1'b1);
    if (pop) void'(m_fifo.pop_front());
    if (push_req) begin
      if (m_fifo.size() >= 2) e_ov = 1;
      else m_fifo.push_back(m_dt);
    end
    if (m_fifo.size() > 0) m_q = m_fifo[0];
    code = e_ill ? 2'b01 : e_ov ? 2'b11 : e_to ? 2'b10 : 2'b00;
    if (code != 2'b00 && (!m_err || CLR_ERR === 1'b1)) begin
      m_err = 1'b1; m_code = code;
    end else if (CLR_ERR === 1'b1) begin
      m_err = 1'b0; m_code = 2'b00;
    end
    m_dt = DT; m_df = DF; m_sampled = 1;
  endfunction

  task automatic tick();
    model_step();
    @(posedge CP);
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] d);
    DT = '0; DF = '0; tick();
    DT = d;  DF = ~d; tick();
  endtask

  task automatic drain();
    QR = 1'b1; DT = '0; DF = '0;
    repeat (3) tick();
    QR = 1'b0;
  endtask

  task automatic clear_err();
    CLR_ERR = 1'b1; tick(); CLR_ERR = 1'b0;
  endtask

  task automatic test_reset();
    CDN = 1'b0; model_reset();
    repeat (2) @(posedge CP);
    #1;
    checks++; if (QV !== 1'b0) begin errors++; $display("FAIL reset_qv: got %b want 0", QV); end
    checks++; if (Q !== '0) begin errors++; $display("FAIL reset_q: got %h want 00", Q); end
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", ERR); end
    checks++; if (ERR_CODE !== 2'b00) begin errors++; $display("FAIL reset_code: got %b want 00", ERR_CODE); end
    CDN = 1'b1;
  endtask

  task automatic test_basic();
    DT = '0; DF = '0; tick();
    DT = 8'hA5; DF = 8'h5A; tick();
    checks++; if (QV !== 1'b0) begin errors++; $display("FAIL basic_early_qv: got %b want 0", QV); end
    DT = '0; DF = '0; tick();
    checks++; if (QV !== 1'b1) begin errors++; $display("FAIL basic_qv: got %b want 1", QV); end
    checks++; if (Q !== 8'hA5) begin errors++; $display("FAIL basic_q: got %h want a5", Q); end
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", ERR); end
    drain();
  endtask

  task automatic test_overflow();
    QR = 1'b0;
    send_word(8'h01); send_word(8'h02); send_word(8'h03);
    DT = '0; DF = '0; tick();
    checks++; if (QV !== 1'b1 || Q !== 8'h01) begin errors++; $display("FAIL ovf_head: got qv=%b q=%h want qv=1 q=01", QV, Q); end
    checks++; if (ERR !== 1'b1 || ERR_CODE !== 2'b11) begin errors++; $display("FAIL ovf_err: got %b/%b want 1/11", ERR, ERR_CODE); end
    QR = 1'b1; tick();
    checks++; if (QV !== 1'b1 || Q !== 8'h02) begin errors++; $display("FAIL ovf_pop1: got qv=%b q=%h want qv=1 q=02", QV, Q); end
    tick();
    checks++; if (QV !== 1'b0 || Q !== 8'h02) begin errors++; $display("FAIL ovf_pop2: got qv=%b q=%h want qv=0 q=02", QV, Q); end
    QR = 1'b0;
    clear_err();
    checks++; if (ERR !== 1'b0 || ERR_CODE !== 2'b00) begin errors++; $display("FAIL ovf_clr: got %b/%b want 0/00", ERR, ERR_CODE); end
  endtask

  task automatic test_illegal();
    DT = '0; DF = '0; tick();
    DT = 8'hAD; DF = 8'h5A; tick();
    DT = '0; DF = '0; tick();
    checks++; if (ERR !== 1'b1 || ERR_CODE !== 2'b01) begin errors++; $display("FAIL ill_err: got %b/%b want 1/01", ERR, ERR_CODE); end
    checks++; if (QV !== 1'b0) begin errors++; $display("FAIL ill_nopush: got %b want 0", QV); end
    send_word(8'h3C);
    DT = '0; DF = '0; tick();
    checks++; if (QV !== 1'b1 || Q !== 8'h3C) begin errors++; $display("FAIL ill_recover: got qv=%b q=%h want qv=1 q=3c", QV, Q); end
    clear_err();
    drain();
  endtask

  task automatic test_timeout();
    DT = 8'h0F; DF = 8'h00;
    repeat (TO) tick();
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL to_early: got %b want 0", ERR); end
    DT = '0; DF = '0; tick();
    checks++; if (ERR !== 1'b1 || ERR_CODE !== 2'b10) begin errors++; $display("FAIL to_err: got %b/%b want 1/10", ERR, ERR_CODE); end
    checks++; if (QV !== 1'b0) begin errors++; $display("FAIL to_nopush: got %b want 0", QV); end
    clear_err();
    DT = 8'h0F; DF = 8'h00;
    repeat (TO - 1) tick();
    DT = 8'h0F; DF = 8'hF0; tick();
    DT = '0; DF = '0; tick();
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL to_edge_err: got %b want 0", ERR); end
    checks++; if (QV !== 1'b1 || Q !== 8'h0F) begin errors++; $display("FAIL to_edge_push: got qv=%b q=%h want qv=1 q=0f", QV, Q); end
    drain();
  endtask

  task automatic test_repeat_and_clr();
    DT = 8'hC3; DF = 8'h3C;
    repeat (5) tick();
    DT = '0; DF = '0; tick();
    checks++; if (QV !== 1'b1 || Q !== 8'hC3) begin errors++; $display("FAIL rep_push: got qv=%b q=%h want qv=1 q=c3", QV, Q); end
    QR = 1'b1; tick(); QR = 1'b0;
    checks++; if (QV !== 1'b0) begin errors++; $display("FAIL rep_single: got %b want 0", QV); end
    DT = 8'h0F; DF = 8'h00;
    repeat (TO + 1) tick();
    DT = '0; DF = '0; tick();
    checks++; if (ERR !== 1'b1 || ERR_CODE !== 2'b10) begin errors++; $display("FAIL clr_pre: got %b/%b want 1/10", ERR, ERR_CODE); end
    DT = 8'hFF; DF = 8'hFF; tick();
    DT = '0; DF = '0; CLR_ERR = 1'b1; tick(); CLR_ERR = 1'b0;
    checks++; if (ERR !== 1'b1 || ERR_CODE !== 2'b01) begin errors++; $display("FAIL clr_vs_new: got %b/%b want 1/01", ERR, ERR_CODE); end
    clear_err();
    tick();
  endtask

  task automatic test_async_reset();
    send_word(8'h5A);
    DT = '0; DF = '0; tick();
    checks++; if (QV !== 1'b1 || Q !== 8'h5A) begin errors++; $display("FAIL ar_pre: got qv=%b q=%h want qv=1 q=5a", QV, Q); end
    DT = 8'h0F; DF = 8'h00; tick();
    #3 CDN = 1'b0;
    #1;
    checks++; if (QV !== 1'b0 || Q !== '0) begin errors++; $display("FAIL ar_immediate: got qv=%b q=%h want qv=0 q=00", QV, Q); end
    model_reset();
    DT = 8'h77; DF = 8'h88;
    @(posedge CP); #1;
    CDN = 1'b1;
    repeat (4) tick();
    checks++; if (QV !== 1'b0) begin errors++; $display("FAIL ar_ignore: got %b want 0", QV); end
    send_word(8'h77);
    DT = '0; DF = '0; tick();
    checks++; if (QV !== 1'b1 || Q !== 8'h77) begin errors++; $display("FAIL ar_after: got qv=%b q=%h want qv=1 q=77", QV, Q); end
    drain();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      int kind;
      int hold;
      logic [W-1:0] r, m;
      kind = int'($urandom_range(0, 99));
      r = W'($urandom);
      if (kind < 40) begin
        DT = '0; DF = '0; hold = int'($urandom_range(1, 2));
      end else if (kind < 80) begin
        DT = r; DF = ~r; hold = int'($urandom_range(1, 3));
      end else if (kind < 95) begin
        m = W'($urandom);
        DT = r & m; DF = ~r & m; hold = int'($urandom_range(1, 20));
      end else begin
        m = '0; m[$urandom_range(0, W - 1)] = 1'b1;
        DT = r | m; DF = ~r | m; hold = 1;
      end
      for (int h = 0; h < hold; h++) begin
        QR = 1'($urandom_range(0, 1));
        CLR_ERR = ($urandom_range(0, 29) == 0);
        tick();
        checks++; if (QV !== (m_fifo.size() > 0)) begin errors++; $display("FAIL rnd_qv@%0d: got %b want %b", n, QV, (m_fifo.size() > 0)); end
        checks++; if (Q !== m_q) begin errors++; $display("FAIL rnd_q@%0d: got %h want %h", n, Q, m_q); end
        checks++; if (ERR !== m_err) begin errors++; $display("FAIL rnd_err@%0d: got %b want %b", n, ERR, m_err); end
        checks++; if (ERR_CODE !== m_code) begin errors++; $display("FAIL rnd_code@%0d: got %b want %b", n, ERR_CODE, m_code); end
      end
    end
    QR = 1'b0; CLR_ERR = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_illegal();
    test_timeout();
    test_repeat_and_clr();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
